// File: rtl/data_path_pkg.sv
// Shared definitions for the data_path slice.
//   WORD_W     : datapath word width (32)
//   alu_op_e   : ALU operation (NONE, INCPC, AND, OR, ADD, SUB)
//   alu_decode : folds the one-hot-ish op selects into alu_op_e by priority
//   alu_lo     : low-word ALU result
//   alu_hi     : high-word result, used only when DATAPATH_ZHI_EN is defined
package data_path_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [2:0] {NONE, INCPC, AND, OR, ADD, SUB} alu_op_e;

   function automatic alu_op_e alu_decode(input logic inc_pc, input logic op_and,
                                          input logic op_or, input logic op_add,
                                          input logic op_sub);
      if (inc_pc)      return INCPC;
      else if (op_and) return AND;
      else if (op_or)  return OR;
      else if (op_add) return ADD;
      else if (op_sub) return SUB;
      else             return NONE;
   endfunction

   function automatic logic [WORD_W-1:0] alu_lo(input alu_op_e op,
                                                input logic [WORD_W-1:0] a,
                                                input logic [WORD_W-1:0] b);
      case (op)
         INCPC:   return b + 32'd1;
         AND:     return a & b;
         OR:      return a | b;
         ADD:     return a + b;
         SUB:     return a - b;
         default: return '0;
      endcase
   endfunction

   // ADD: carry-out zero-extended; SUB: sign of the low result replicated.
   function automatic logic [WORD_W-1:0] alu_hi(input alu_op_e op,
                                                input logic [WORD_W-1:0] a,
                                                input logic [WORD_W-1:0] b);
      logic [WORD_W:0]   sum;
      logic [WORD_W-1:0] diff;
      sum  = {1'b0, a} + {1'b0, b};
      diff = a - b;
      case (op)
         ADD:     return {{(WORD_W-1){1'b0}}, sum[WORD_W]};
         SUB:     return {WORD_W{diff[WORD_W-1]}};
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/data_path_register_32.sv
// register_32: 32-bit load-enable register with synchronous active-high clear.
//   Clock  : rising-edge clock
//   Clear  : synchronous clear, wins over enable
//   enable : load d on the rising edge
//   d / q  : data in / registered data out
module register_32
   import data_path_pkg::*;
(
   input  logic              Clock,
   input  logic              Clear,
   input  logic              enable,
   input  logic [WORD_W-1:0] d,
   output logic [WORD_W-1:0] q
);

   always_ff @(posedge Clock) begin
      if (Clear)       q <= '0;
      else if (enable) q <= d;
   end

endmodule

// File: rtl/data_path.sv
// data_path: single-bus register datapath (PC, IR, MAR, MDR, Y, Zlo, R3, R4, R7)
// with a combinational ALU feeding Zlo. No functional outputs; internal nets
// (BusMuxOut, BusMuxIn*, Y_Out, MAR.q) are observed hierarchically.
//   Clock, Clear          : clock and synchronous active-high clear
//   PCout..R7out          : bus source selects, priority PCout > Zlowout > MDRout > R3out > R7out
//   PCin..R7in            : register load enables
//   IncPC, AND, OR, ADD, SUB : ALU op selects, priority in that order
//   Read                  : MDR input select (1 = Mdatain, 0 = bus)
//   Mdatain               : memory read data
// Optional feature macro DATAPATH_ZHI_EN adds register Zhi, input Zhighout
// (lowest bus priority) and net BusMuxInZhi.
module data_path (
   input  logic                              Clock,
   input  logic                              Clear,
   input  logic                              PCout,
   input  logic                              Zlowout,
   input  logic                              MDRout,
   input  logic                              R3out,
   input  logic                              R7out,
`ifdef DATAPATH_ZHI_EN
   input  logic                              Zhighout,
`endif
   input  logic                              PCin,
   input  logic                              MARin,
   input  logic                              MDRin,
   input  logic                              IRin,
   input  logic                              Yin,
   input  logic                              Zin,
   input  logic                              R3in,
   input  logic                              R4in,
   input  logic                              R7in,
   input  logic                              IncPC,
   input  logic                              AND,
   input  logic                              OR,
   input  logic                              ADD,
   input  logic                              SUB,
   input  logic                              Read,
   input  logic [data_path_pkg::WORD_W-1:0]  Mdatain
);

   // Imported here, after the ports, so the op-select ports shadow the
   // same-named enum literals; the ALU goes through package functions.
   import data_path_pkg::*;

   logic [WORD_W-1:0] BusMuxOut;
   logic [WORD_W-1:0] BusMuxInPC, BusMuxInIR, BusMuxInMDR, BusMuxInZlo;
   logic [WORD_W-1:0] BusMuxInR3, BusMuxInR4, BusMuxInR7, Y_Out, mar_q;
   logic [WORD_W-1:0] mdr_d, alu_result;
   alu_op_e           alu_op;

   always_comb begin
      BusMuxOut = '0;
      if (PCout)        BusMuxOut = BusMuxInPC;
      else if (Zlowout) BusMuxOut = BusMuxInZlo;
      else if (MDRout)  BusMuxOut = BusMuxInMDR;
      else if (R3out)   BusMuxOut = BusMuxInR3;
      else if (R7out)   BusMuxOut = BusMuxInR7;
`ifdef DATAPATH_ZHI_EN
      else if (Zhighout) BusMuxOut = BusMuxInZhi;
`endif
   end

   assign mdr_d      = Read ? Mdatain : BusMuxOut;
   assign alu_op     = alu_decode(IncPC, AND, OR, ADD, SUB);
   assign alu_result = alu_lo(alu_op, Y_Out, BusMuxOut);

   register_32 PC  (.Clock(Clock), .Clear(Clear), .enable(PCin),  .d(BusMuxOut),  .q(BusMuxInPC));
   register_32 IR  (.Clock(Clock), .Clear(Clear), .enable(IRin),  .d(BusMuxOut),  .q(BusMuxInIR));
   register_32 MAR (.Clock(Clock), .Clear(Clear), .enable(MARin), .d(BusMuxOut),  .q(mar_q));
   register_32 MDR (.Clock(Clock), .Clear(Clear), .enable(MDRin), .d(mdr_d),      .q(BusMuxInMDR));
   register_32 Y   (.Clock(Clock), .Clear(Clear), .enable(Yin),   .d(BusMuxOut),  .q(Y_Out));
   register_32 Zlo (.Clock(Clock), .Clear(Clear), .enable(Zin),   .d(alu_result), .q(BusMuxInZlo));
   register_32 R3  (.Clock(Clock), .Clear(Clear), .enable(R3in),  .d(BusMuxOut),  .q(BusMuxInR3));
   register_32 R4  (.Clock(Clock), .Clear(Clear), .enable(R4in),  .d(BusMuxOut),  .q(BusMuxInR4));
   register_32 R7  (.Clock(Clock), .Clear(Clear), .enable(R7in),  .d(BusMuxOut),  .q(BusMuxInR7));

`ifdef DATAPATH_ZHI_EN
   logic [WORD_W-1:0] BusMuxInZhi;
   logic [WORD_W-1:0] alu_result_hi;

   assign alu_result_hi = alu_hi(alu_op, Y_Out, BusMuxOut);

   register_32 Zhi (.Clock(Clock), .Clear(Clear), .enable(Zin), .d(alu_result_hi), .q(BusMuxInZhi));
`endif

endmodule

// File: tb/tb_data_path.sv
// Directed self-checking bench for data_path. Inputs change and outputs are
// sampled on the falling edge; registers update on the rising edge.
module tb_data_path;

   logic        Clock = 1'b0;
   logic        Clear;
   logic        PCout, Zlowout, MDRout, R3out, R7out;
   logic        PCin, MARin, MDRin, IRin, Yin, Zin, R3in, R4in, R7in;
   logic        IncPC, AND, OR, ADD, SUB, Read;
   logic [31:0] Mdatain;
`ifdef DATAPATH_ZHI_EN
   logic        Zhighout;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 Clock = ~Clock;

   data_path dut (
      .Clock(Clock), .Clear(Clear),
      .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .R3out(R3out), .R7out(R7out),
`ifdef DATAPATH_ZHI_EN
      .Zhighout(Zhighout),
`endif
      .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
      .R3in(R3in), .R4in(R4in), .R7in(R7in),
      .IncPC(IncPC), .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB),
      .Read(Read), .Mdatain(Mdatain)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic idle();
      Clear = 0; PCout = 0; Zlowout = 0; MDRout = 0; R3out = 0; R7out = 0;
      PCin = 0; MARin = 0; MDRin = 0; IRin = 0; Yin = 0; Zin = 0;
      R3in = 0; R4in = 0; R7in = 0;
      IncPC = 0; AND = 0; OR = 0; ADD = 0; SUB = 0; Read = 0; Mdatain = '0;
`ifdef DATAPATH_ZHI_EN
      Zhighout = 0;
`endif
   endtask

   // One rising edge with the current controls, then back to idle at the falling edge.
   task automatic tick();
      @(posedge Clock);
      @(negedge Clock);
      idle();
   endtask

   task automatic load_mdr(input logic [31:0] v);
      Read = 1; MDRin = 1; Mdatain = v;
      tick();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_pc"},  dut.BusMuxInPC,  32'h0);
      chk({tag, "_ir"},  dut.BusMuxInIR,  32'h0);
      chk({tag, "_mar"}, dut.MAR.q,       32'h0);
      chk({tag, "_mdr"}, dut.BusMuxInMDR, 32'h0);
      chk({tag, "_y"},   dut.Y_Out,       32'h0);
      chk({tag, "_zlo"}, dut.BusMuxInZlo, 32'h0);
      chk({tag, "_r3"},  dut.BusMuxInR3,  32'h0);
      chk({tag, "_r4"},  dut.BusMuxInR4,  32'h0);
      chk({tag, "_r7"},  dut.BusMuxInR7,  32'h0);
`ifdef DATAPATH_ZHI_EN
      chk({tag, "_zhi"}, dut.BusMuxInZhi, 32'h0);
`endif
   endtask

   typedef struct {
      int          op;      // 0 AND, 1 OR, 2 ADD, 3 SUB
      logic [31:0] exp_r4;
      logic [31:0] exp_zhi;
   } exec_vec_t;

   exec_vec_t exec_tbl [4] = '{
      '{0, 32'h0000_0020, 32'h0000_0000},
      '{1, 32'h0000_0026, 32'h0000_0000},
      '{2, 32'h0000_0046, 32'h0000_0000},
      '{3, 32'hFFFF_FFFE, 32'hFFFF_FFFF}
   };

   initial begin
      idle();
      @(negedge Clock);
      Clear = 1;
      tick();
      chk_all_zero("reset");
      #1 chk("bus_none", dut.BusMuxOut, 32'h0);

      // Register loads through MDR.
      load_mdr(32'h22);
      chk("mdr_load", dut.BusMuxInMDR, 32'h22);
      MDRout = 1; R3in = 1; tick();
      chk("r3_load", dut.BusMuxInR3, 32'h22);
      load_mdr(32'h24);
      MDRout = 1; R7in = 1; tick();
      chk("r7_load", dut.BusMuxInR7, 32'h24);
      load_mdr(32'h28);
      MDRout = 1; R4in = 1; tick();
      chk("r4_load", dut.BusMuxInR4, 32'h28);

      // Instruction fetch.
      PCout = 1; MARin = 1; IncPC = 1; Zin = 1; tick();
      chk("t0_mar", dut.MAR.q, 32'h0);
      chk("t0_zlo", dut.BusMuxInZlo, 32'h1);
      Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h2A2B_8000; tick();
      chk("t1_pc", dut.BusMuxInPC, 32'h1);
      chk("t1_mdr", dut.BusMuxInMDR, 32'h2A2B_8000);
      MDRout = 1; IRin = 1; tick();
      chk("t2_ir", dut.BusMuxInIR, 32'h2A2B_8000);

      // Execute each ALU op: R4 <= R3 op R7.
      foreach (exec_tbl[i]) begin
         R3out = 1; Yin = 1; tick();
         chk("exec_y", dut.Y_Out, 32'h22);
         R7out = 1; Zin = 1;
         case (exec_tbl[i].op)
            0: AND = 1;
            1: OR  = 1;
            2: ADD = 1;
            default: SUB = 1;
         endcase
         tick();
`ifdef DATAPATH_ZHI_EN
         chk($sformatf("exec_zhi_%0d", i), dut.BusMuxInZhi, exec_tbl[i].exp_zhi);
`endif
         Zlowout = 1; R4in = 1; tick();
         chk($sformatf("exec_r4_%0d", i), dut.BusMuxInR4, exec_tbl[i].exp_r4);
      end

      // Bus priority: PC=5, MDR=9.
      load_mdr(32'h5);
      MDRout = 1; PCin = 1; tick();
      load_mdr(32'h9);
      PCout = 1; MDRout = 1;
      #1 chk("prio_pc_mdr", dut.BusMuxOut, 32'h5);
      PCout = 0;
      #1 chk("prio_mdr_only", dut.BusMuxOut, 32'h9);
      R3out = 1; R7out = 1;
      #1 chk("prio_mdr_r3", dut.BusMuxOut, 32'h9);
      MDRout = 0;
      #1 chk("prio_r3_r7", dut.BusMuxOut, 32'h22);
`ifdef DATAPATH_ZHI_EN
      R3out = 0; Zhighout = 1;
      #1 chk("prio_r7_zhi", dut.BusMuxOut, 32'h24);
`endif
      idle();

      // ALU priority: AND beats ADD with Y=3, B=5.
      load_mdr(32'h3);
      MDRout = 1; Yin = 1; tick();
      load_mdr(32'h5);
      MDRout = 1; AND = 1; ADD = 1; Zin = 1; tick();
      chk("alu_and_over_add", dut.BusMuxInZlo, 32'h1);

      // Register as bus source while being loaded: old value on bus, new captured.
      load_mdr(32'h11);
      MDRout = 1; Read = 1; MDRin = 1; Mdatain = 32'h77; R4in = 1;
      #1 chk("same_cycle_bus", dut.BusMuxOut, 32'h11);
      tick();
      chk("same_cycle_mdr", dut.BusMuxInMDR, 32'h77);
      chk("same_cycle_r4", dut.BusMuxInR4, 32'h11);

      // Wrap: 0xFFFFFFFF + 1.
      load_mdr(32'hFFFF_FFFF);
      MDRout = 1; Yin = 1; tick();
      load_mdr(32'h1);
      MDRout = 1; ADD = 1; Zin = 1; tick();
      chk("wrap_zlo", dut.BusMuxInZlo, 32'h0);
`ifdef DATAPATH_ZHI_EN
      chk("wrap_zhi", dut.BusMuxInZhi, 32'h1);
`endif

      // Clear mid-instruction wins over every load enable.
      load_mdr(32'h46);
      MDRout = 1; R4in = 1; Yin = 1; Zin = 1; ADD = 1; PCin = 1; MARin = 1;
      IRin = 1; R3in = 1; R7in = 1; Clear = 1;
      tick();
      chk_all_zero("clear");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
